// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a req/done run handshake, stall, a LIFO
// call/return stack and sticky stack-error flags.
module pc_sequencer #(
  parameter int unsigned D          = 12,
  parameter int unsigned SD         = 4,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned END_ADDR   = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     stall,
  input  logic                     rel_en,
  input  logic                     abs_en,
  input  logic                     call_en,
  input  logic                     ret_en,
  input  logic [D-1:0]             target,
  output logic [D-1:0]             prog_ctr,
  output logic                     running,
  output logic                     done,
  output logic [$clog2(SD+1)-1:0]  stk_depth,
  output logic                     stk_ovf,
  output logic                     stk_unf
);

  localparam int unsigned DW = $clog2(SD + 1);
  localparam int unsigned AW = (SD > 1) ? $clog2(SD) : 1;
  localparam logic [D-1:0] START_PC = D'(START_ADDR);
  localparam logic [D-1:0] END_PC   = D'(END_ADDR);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [D-1:0]   stack [SD];
  logic [D-1:0]   pc_inc;
  logic [AW-1:0]  push_idx;
  logic [AW-1:0]  top_idx;
  logic           active;
  logic           push;

  assign running  = (state == RUN);
  assign done     = (state == DONE);
  assign pc_inc   = prog_ctr + D'(1);
  assign push_idx = AW'(stk_depth);
  assign top_idx  = AW'(stk_depth - DW'(1));

  // A call only pushes when it wins priority and the stack has room.
  assign active = (state == RUN) && (prog_ctr != END_PC) && !stall;
  assign push   = active && !ret_en && call_en && (stk_depth < DW'(SD));

  // NOTE: the stack array has no reset; stk_depth alone defines which
  // entries are valid, so clearing the storage would only cost flops.
  always_ff @(posedge clk) begin
    if (push) stack[push_idx] <= pc_inc;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // branch reads the pre-edge values of prog_ctr, stk_depth and the stack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prog_ctr  <= START_PC;
      stk_depth <= '0;
      stk_ovf   <= 1'b0;
      stk_unf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          prog_ctr <= START_PC;
          if (req) state <= RUN;
        end
        RUN: begin
          if (prog_ctr == END_PC) begin
            state <= DONE;
          end else if (!stall) begin
            if (ret_en) begin
              if (stk_depth != '0) begin
                prog_ctr  <= stack[top_idx];
                stk_depth <= stk_depth - DW'(1);
              end else begin
                stk_unf  <= 1'b1;
                prog_ctr <= pc_inc;
              end
            end else if (call_en) begin
              if (stk_depth < DW'(SD)) begin
                prog_ctr  <= target;
                stk_depth <= stk_depth + DW'(1);
              end else begin
                stk_ovf  <= 1'b1;
                prog_ctr <= pc_inc;
              end
            end else if (abs_en) begin
              prog_ctr <= target;
            end else if (rel_en) begin
              // Same-width add is the sign-extended offset modulo 2^D.
              prog_ctr <= prog_ctr + target;
            end else begin
              prog_ctr <= pc_inc;
            end
          end
        end
        DONE: begin
          if (!req) begin
            state     <= IDLE;
            prog_ctr  <= START_PC;
            stk_depth <= '0;
            stk_ovf   <= 1'b0;
            stk_unf   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed table, hand sequences for
// stack/reset corners, and randomized traffic against a queue-based model.
module tb_pc_sequencer;

  localparam int D      = 12;
  localparam int SD     = 4;
  localparam int START  = 0;
  localparam int ENDA   = 128;
  localparam int PCMOD  = 1 << D;
  localparam int DW     = $clog2(SD + 1);

  typedef struct packed {
    logic         req;
    logic         stall;
    logic         rel_en;
    logic         abs_en;
    logic         call_en;
    logic         ret_en;
    logic [D-1:0] target;
  } ctl_t;

  typedef struct {
    ctl_t c;
    int   exp_pc;
    int   exp_depth;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req, stall, rel_en, abs_en, call_en, ret_en;
  logic [D-1:0]  target;
  logic [D-1:0]  prog_ctr;
  logic          running, done;
  logic [DW-1:0] stk_depth;
  logic          stk_ovf, stk_unf;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode flags, integer PC, queue as the call stack.
  bit m_run, m_done;
  int m_pc;
  int m_stack[$];
  bit m_ovf, m_unf;

  pc_sequencer #(.D(D), .SD(SD), .START_ADDR(START), .END_ADDR(ENDA)) dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .rel_en(rel_en),
    .abs_en(abs_en), .call_en(call_en), .ret_en(ret_en), .target(target),
    .prog_ctr(prog_ctr), .running(running), .done(done),
    .stk_depth(stk_depth), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ctl_t mk(bit ret, bit call, bit absj, bit rel, bit stl, int tgt);
    ctl_t c;
    c.req = 1'b1; c.stall = stl; c.rel_en = rel; c.abs_en = absj;
    c.call_en = call; c.ret_en = ret; c.target = D'(tgt);
    return c;
  endfunction

  function automatic ctl_t idle_ctl(bit r);
    ctl_t c = mk(0, 0, 0, 0, 0, 0);
    c.req = r;
    return c;
  endfunction

  task automatic model_reset();
    m_run = 0; m_done = 0; m_pc = START;
    m_stack.delete();
    m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_step(input ctl_t c);
    int off;
    if (m_done) begin
      if (!c.req) model_reset();
    end else if (m_run) begin
      if (m_pc == ENDA) begin
        m_run = 0; m_done = 1;
      end else if (!c.stall) begin
        if (c.ret_en) begin
          if (m_stack.size() > 0) m_pc = m_stack.pop_back();
          else begin m_unf = 1; m_pc = (m_pc + 1) % PCMOD; end
        end else if (c.call_en) begin
          if (m_stack.size() < SD) begin
            m_stack.push_back((m_pc + 1) % PCMOD);
            m_pc = int'(c.target);
          end else begin
            m_ovf = 1; m_pc = (m_pc + 1) % PCMOD;
          end
        end else if (c.abs_en) begin
          m_pc = int'(c.target);
        end else if (c.rel_en) begin
          off  = (int'(c.target) >= PCMOD / 2) ? int'(c.target) - PCMOD : int'(c.target);
          m_pc = (m_pc + off + PCMOD) % PCMOD;
        end else begin
          m_pc = (m_pc + 1) % PCMOD;
        end
      end
    end else if (c.req) begin
      m_run = 1; m_pc = START;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, " prog_ctr"}, int'(prog_ctr), m_pc);
    check({tag, " running"}, int'(running), int'(m_run));
    check({tag, " done"}, int'(done), int'(m_done));
    check({tag, " stk_depth"}, int'(stk_depth), m_stack.size());
    check({tag, " stk_ovf"}, int'(stk_ovf), int'(m_ovf));
    check({tag, " stk_unf"}, int'(stk_unf), int'(m_unf));
  endtask

  // Apply controls after a falling edge, clock once, compare on the next fall.
  task automatic cyc(input ctl_t c, input string tag);
    req = c.req; stall = c.stall; rel_en = c.rel_en; abs_en = c.abs_en;
    call_en = c.call_en; ret_en = c.ret_en; target = c.target;
    @(posedge clk);
    model_step(c);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
    #1;
    reset = 1'b0;
  endtask

  vec_t tbl[9];

  initial begin
    reset = 1'b1;
    req = 0; stall = 0; rel_en = 0; abs_en = 0; call_en = 0; ret_en = 0; target = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    reset = 1'b0;

    // Test 1: straight run 0..128, done one cycle later, back to IDLE.
    cyc(idle_ctl(0), "idle hold");
    cyc(idle_ctl(1), "t1 start");
    check("t1 first pc", int'(prog_ctr), START);
    for (int i = 1; i <= ENDA; i++) begin
      cyc(idle_ctl(1), "t1 run");
      check("t1 pc seq", int'(prog_ctr), i);
      check("t1 not done", int'(done), 0);
    end
    cyc(idle_ctl(1), "t1 end");
    check("t1 done", int'(done), 1);
    check("t1 pc at end", int'(prog_ctr), ENDA);
    cyc(idle_ctl(1), "t1 done hold");
    check("t1 done held", int'(done), 1);
    cyc(idle_ctl(0), "t1 to idle");
    check("t1 idle pc", int'(prog_ctr), START);
    check("t1 idle done", int'(done), 0);

    // Test 2: table of call/ret/rel/abs/stall starting from pc=5.
    tbl[0] = '{mk(0, 1, 0, 0, 0, 40),     40, 1};
    tbl[1] = '{mk(0, 0, 0, 0, 0, 0),      41, 1};
    tbl[2] = '{mk(0, 0, 0, 0, 0, 0),      42, 1};
    tbl[3] = '{mk(1, 0, 0, 0, 0, 0),       6, 0};
    tbl[4] = '{mk(0, 0, 0, 1, 0, 'hFFD),   3, 0};
    tbl[5] = '{mk(0, 0, 1, 0, 0, 100),   100, 0};
    tbl[6] = '{mk(0, 0, 0, 1, 1, 5),     100, 0};
    tbl[7] = '{mk(0, 1, 0, 0, 0, 50),     50, 1};
    tbl[8] = '{mk(1, 0, 0, 0, 0, 0),     101, 0};
    cyc(idle_ctl(1), "t2 start");
    repeat (5) cyc(idle_ctl(1), "t2 walk");
    check("t2 at 5", int'(prog_ctr), 5);
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].c, "t2 vec");
      check($sformatf("t2 vec%0d pc", i), int'(prog_ctr), tbl[i].exp_pc);
      check($sformatf("t2 vec%0d depth", i), int'(stk_depth), tbl[i].exp_depth);
    end

    // Test 3: overflow on the fifth call, underflow on an empty return.
    @(negedge clk); pulse_reset("t3 reset");
    cyc(idle_ctl(1), "t3 start");
    repeat (5) cyc(mk(0, 1, 0, 0, 0, 50), "t3 call");
    check("t3 depth full", int'(stk_depth), SD);
    check("t3 ovf", int'(stk_ovf), 1);
    check("t3 ovf pc", int'(prog_ctr), 51);
    repeat (4) cyc(mk(1, 0, 0, 0, 0, 0), "t3 ret");
    check("t3 unwound pc", int'(prog_ctr), 1);
    cyc(mk(1, 0, 0, 0, 0, 0), "t3 ret empty");
    check("t3 unf", int'(stk_unf), 1);
    check("t3 unf pc", int'(prog_ctr), 2);
    cyc(mk(0, 0, 1, 0, 0, ENDA), "t3 jump end");
    cyc(idle_ctl(1), "t3 done");
    check("t3 ovf sticky", int'(stk_ovf), 1);
    check("t3 unf sticky", int'(stk_unf), 1);
    cyc(idle_ctl(0), "t3 idle");
    check("t3 ovf cleared", int'(stk_ovf), 0);
    check("t3 unf cleared", int'(stk_unf), 0);

    // Test 4: ret wins over call/abs; stall freezes a relative jump.
    cyc(idle_ctl(1), "t4 start");
    repeat (6) cyc(idle_ctl(1), "t4 walk");
    cyc(mk(0, 1, 0, 0, 0, 30), "t4 call");
    cyc(mk(1, 1, 1, 0, 0, 99), "t4 priority");
    check("t4 ret pc", int'(prog_ctr), 7);
    check("t4 ret depth", int'(stk_depth), 0);
    repeat (3) cyc(mk(0, 0, 0, 1, 1, 10), "t4 stall");
    check("t4 stall pc", int'(prog_ctr), 7);
    check("t4 stall flags", int'({stk_ovf, stk_unf}), 0);

    // Test 5: wrap at 2^D-1 by increment and by relative jump.
    cyc(mk(0, 0, 1, 0, 0, PCMOD - 1), "t5 abs max");
    cyc(idle_ctl(1), "t5 wrap");
    check("t5 wrap pc", int'(prog_ctr), 0);
    cyc(mk(0, 0, 1, 0, 0, PCMOD - 1), "t5 abs max2");
    cyc(mk(0, 0, 0, 1, 0, 2), "t5 rel wrap");
    check("t5 rel wrap pc", int'(prog_ctr), 1);

    // Test 6: reset mid-run clears immediately; end check beats stall.
    cyc(mk(0, 0, 1, 0, 0, 0), "t6 home");
    repeat (5) cyc(mk(0, 1, 0, 0, 0, 50), "t6 call");
    repeat (2) cyc(mk(1, 0, 0, 0, 0, 0), "t6 ret");
    cyc(mk(0, 0, 1, 0, 0, 77), "t6 to 77");
    check("t6 pre depth", int'(stk_depth), 2);
    check("t6 pre ovf", int'(stk_ovf), 1);
    pulse_reset("t6 async");
    check("t6 async pc", int'(prog_ctr), START);
    check("t6 async running", int'(running), 0);
    cyc(idle_ctl(1), "t6 restart");
    cyc(mk(0, 0, 1, 0, 0, ENDA), "t6 to end");
    cyc(mk(0, 1, 0, 1, 1, 9), "t6 end stall");
    check("t6 done over stall", int'(done), 1);
    check("t6 end pc", int'(prog_ctr), ENDA);
    check("t6 end depth", int'(stk_depth), 0);
    cyc(idle_ctl(0), "t6 idle");

    // Randomized traffic, with occasional async reset pulses.
    for (int i = 0; i < 3000; i++) begin
      ctl_t c;
      int   tgt;
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset("rnd reset");
      end else begin
        case ($urandom_range(0, 5))
          0:       tgt = int'($urandom_range(0, PCMOD - 1));
          1:       tgt = ENDA;
          2:       tgt = PCMOD - int'($urandom_range(1, 8));
          default: tgt = int'($urandom_range(0, 140));
        endcase
        c.req     = ($urandom_range(0, 9) != 0);
        c.stall   = ($urandom_range(0, 4) == 0);
        c.rel_en  = ($urandom_range(0, 3) == 0);
        c.abs_en  = ($urandom_range(0, 5) == 0);
        c.call_en = ($urandom_range(0, 4) == 0);
        c.ret_en  = ($urandom_range(0, 4) == 0);
        c.target  = D'(tgt);
        cyc(c, "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
